// File: rtl/controlador_memoria_instrucoes.sv
// -----------------------------------------------------------------------------
// controlador_memoria_instrucoes
//
// Loader and fetch arbiter for the CPU's writable instruction store.
// After reset the CPU is held (o_cpu_liberado = 0) until a program image has
// been streamed in word by word. The CPU is then released and its fetches are
// served with a fixed one-cycle latency. A fetch beyond the loaded image
// returns HALT_WORD and sets the sticky o_erro_pc flag. A new load may
// pre-empt execution at any time.
//
// Ports:
//   i_clock                rising-edge clock
//   i_reset                synchronous, active-high reset
//   i_carga_inicio         pulse: start or restart a program load
//   i_carga_valido         i_carga_dado holds a valid word
//   i_carga_dado[31:0]     program word, written at ascending addresses from 0
//   i_carga_fim            pulse: load complete, release the CPU
//   o_carga_pronto         loader can accept a word this cycle
//   i_busca_req            CPU fetch request for address i_pc
//   i_pc[25:0]             fetch address (word index)
//   o_instrucao[31:0]      fetched instruction (registered, held between fetches)
//   o_busca_pronto         o_instrucao valid (one pulse per served request)
//   o_cpu_liberado         CPU may run
//   o_erro_pc              sticky: a fetch addressed beyond the loaded image
//   o_palavras_carregadas  words written during the current or last load
// -----------------------------------------------------------------------------
module controlador_memoria_instrucoes #(
    parameter int                 MEM_SIZE  = 150,
    parameter int                 CONT_W    = 8,
    parameter logic [31:0]        HALT_WORD = 32'h6000_0000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_carga_inicio,
    input  logic                  i_carga_valido,
    input  logic [31:0]           i_carga_dado,
    input  logic                  i_carga_fim,
    output logic                  o_carga_pronto,
    input  logic                  i_busca_req,
    input  logic [25:0]           i_pc,
    output logic [31:0]           o_instrucao,
    output logic                  o_busca_pronto,
    output logic                  o_cpu_liberado,
    output logic                  o_erro_pc,
    output logic [CONT_W-1:0]     o_palavras_carregadas
);

    typedef enum logic [1:0] {
        ESPERA_CARGA = 2'b00,
        CARREGANDO   = 2'b01,
        EXECUTANDO   = 2'b10
    } estado_t;

    localparam logic [CONT_W-1:0] LP_MEM_SIZE = CONT_W'(MEM_SIZE);
    localparam logic [CONT_W-1:0] LP_UM       = CONT_W'(1);

    estado_t            r_estado;
    estado_t            w_proximo;
    logic [CONT_W-1:0]  r_palavras;      // doubles as the write pointer
    logic [31:0]        r_instrucao;
    logic               r_busca_pronto;
    logic               r_erro_pc;
    logic [31:0]        r_memoria [0:MEM_SIZE-1];

    logic               w_carga_pronto;
    logic               w_aceita;
    logic               w_pc_valido;
    logic [CONT_W-1:0]  w_indice;

    // Ready is decoded from registers only, so it has no path from inputs.
    assign w_carga_pronto = (r_estado == CARREGANDO) && (r_palavras < LP_MEM_SIZE);

    // A restart in the same cycle discards the coincident word.
    assign w_aceita = w_carga_pronto && i_carga_valido && !i_carga_inicio;

    // Full 26-bit unsigned range check; the counter is zero-extended, pc is never truncated.
    assign w_pc_valido = (i_pc < {{(26-CONT_W){1'b0}}, r_palavras});

    // Only used when w_pc_valido holds, which bounds i_pc below MEM_SIZE.
    assign w_indice = i_pc[CONT_W-1:0];

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado <= ESPERA_CARGA;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state decode; carga_inicio wins over every other request.
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            ESPERA_CARGA: begin
                if (i_carga_inicio) begin
                    w_proximo = CARREGANDO;
                end else begin
                    w_proximo = ESPERA_CARGA;
                end
            end
            CARREGANDO: begin
                if (i_carga_inicio) begin
                    w_proximo = CARREGANDO;
                end else if (i_carga_fim) begin
                    w_proximo = EXECUTANDO;
                end else begin
                    w_proximo = CARREGANDO;
                end
            end
            EXECUTANDO: begin
                if (i_carga_inicio) begin
                    w_proximo = CARREGANDO;
                end else begin
                    w_proximo = EXECUTANDO;
                end
            end
            default: begin
                w_proximo = ESPERA_CARGA;
            end
        endcase
    end

    // Load counter, fetch response and sticky error flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_palavras     <= '0;
            r_instrucao    <= 32'h0000_0000;
            r_busca_pronto <= 1'b0;
            r_erro_pc      <= 1'b0;
        end else begin
            r_busca_pronto <= 1'b0;
            case (r_estado)
                ESPERA_CARGA: begin
                    if (i_carga_inicio) begin
                        r_palavras <= '0;
                        r_erro_pc  <= 1'b0;
                    end
                end
                CARREGANDO: begin
                    if (i_carga_inicio) begin
                        r_palavras <= '0;
                        r_erro_pc  <= 1'b0;
                    end else if (w_aceita) begin
                        r_palavras <= r_palavras + LP_UM;
                    end
                end
                EXECUTANDO: begin
                    if (i_carga_inicio) begin
                        // Pre-empted: the coincident fetch is dropped.
                        r_palavras <= '0;
                        r_erro_pc  <= 1'b0;
                    end else if (i_busca_req) begin
                        r_busca_pronto <= 1'b1;
                        if (w_pc_valido) begin
                            r_instrucao <= r_memoria[w_indice];
                        end else begin
                            r_instrucao <= HALT_WORD;
                            r_erro_pc   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_busca_pronto <= 1'b0;
                end
            endcase
        end
    end

    // Instruction store write port; contents survive reset and reloads.
    always_ff @(posedge i_clock) begin
        if (w_aceita) begin
            r_memoria[r_palavras] <= i_carga_dado;
        end
    end

    assign o_carga_pronto        = w_carga_pronto;
    assign o_instrucao           = r_instrucao;
    assign o_busca_pronto        = r_busca_pronto;
    assign o_cpu_liberado        = (r_estado == EXECUTANDO);
    assign o_erro_pc             = r_erro_pc;
    assign o_palavras_carregadas = r_palavras;

endmodule

// File: tb/tb_controlador_memoria_instrucoes.sv
// -----------------------------------------------------------------------------
// Directed testbench for controlador_memoria_instrucoes.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. they show the effect of the edge just taken.
// -----------------------------------------------------------------------------
module tb_controlador_memoria_instrucoes;

    localparam logic [31:0] HALT = 32'h6000_0000;

    logic        clock;
    logic        reset;
    logic        carga_inicio;
    logic        carga_valido;
    logic [31:0] carga_dado;
    logic        carga_fim;
    logic        carga_pronto;
    logic        busca_req;
    logic [25:0] pc;
    logic [31:0] instrucao;
    logic        busca_pronto;
    logic        cpu_liberado;
    logic        erro_pc;
    logic [7:0]  palavras;

    int n_cmp;
    int n_err;

    controlador_memoria_instrucoes dut (
        .i_clock               (clock),
        .i_reset               (reset),
        .i_carga_inicio        (carga_inicio),
        .i_carga_valido        (carga_valido),
        .i_carga_dado          (carga_dado),
        .i_carga_fim           (carga_fim),
        .o_carga_pronto        (carga_pronto),
        .i_busca_req           (busca_req),
        .i_pc                  (pc),
        .o_instrucao           (instrucao),
        .o_busca_pronto        (busca_pronto),
        .o_cpu_liberado        (cpu_liberado),
        .o_erro_pc             (erro_pc),
        .o_palavras_carregadas (palavras)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp = n_cmp + 1;
        if (obs !== esp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    task automatic verifica_reset(input string tag);
        verifica({tag, "_carga_pronto"}, {31'd0, carga_pronto}, 32'd0);
        verifica({tag, "_busca_pronto"}, {31'd0, busca_pronto}, 32'd0);
        verifica({tag, "_cpu_liberado"}, {31'd0, cpu_liberado}, 32'd0);
        verifica({tag, "_erro_pc"},      {31'd0, erro_pc},      32'd0);
        verifica({tag, "_palavras"},     {24'd0, palavras},     32'd0);
        verifica({tag, "_instrucao"},    instrucao,             32'd0);
    endtask

    logic [31:0] img [0:3];

    initial begin
        n_cmp = 0;
        n_err = 0;
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
        reset = 1'b1; carga_inicio = 1'b0; carga_valido = 1'b0; carga_dado = 32'd0;
        carga_fim = 1'b0; busca_req = 1'b0; pc = 26'd0;
        #2;
        tick(); tick();
        verifica_reset("rst");
        reset = 1'b0;

        // Fetch while waiting for a load is ignored.
        busca_req = 1'b1; pc = 26'd0;
        tick();
        verifica("espera_busca_pronto", {31'd0, busca_pronto}, 32'd0);
        verifica("espera_cpu", {31'd0, cpu_liberado}, 32'd0);
        busca_req = 1'b0;

        // Load four words.
        carga_inicio = 1'b1;
        tick();
        carga_inicio = 1'b0;
        verifica("ini_carga_pronto", {31'd0, carga_pronto}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            carga_valido = 1'b1; carga_dado = img[i];
            tick();
            verifica("carga_contagem", {24'd0, palavras}, i + 1);
        end
        carga_valido = 1'b0;
        carga_fim = 1'b1;
        tick();
        carga_fim = 1'b0;
        verifica("fim_cpu_liberado", {31'd0, cpu_liberado}, 32'd1);
        verifica("fim_carga_pronto", {31'd0, carga_pronto}, 32'd0);

        // Back-to-back fetches pc=0..3.
        for (int i = 0; i < 4; i++) begin
            busca_req = 1'b1; pc = 26'(i);
            tick();
            verifica("b2b_pronto", {31'd0, busca_pronto}, 32'd1);
            verifica("b2b_instrucao", instrucao, img[i]);
        end
        busca_req = 1'b0;
        tick();
        verifica("ocioso_pronto", {31'd0, busca_pronto}, 32'd0);
        verifica("ocioso_instrucao_mantida", instrucao, 32'h44);
        verifica("ocioso_erro", {31'd0, erro_pc}, 32'd0);
        verifica("ocioso_palavras", {24'd0, palavras}, 32'd4);

        // Out-of-image fetches, then an in-range one: error stays set.
        busca_req = 1'b1; pc = 26'd4;
        tick();
        verifica("fora_pc4_instr", instrucao, HALT);
        verifica("fora_pc4_erro", {31'd0, erro_pc}, 32'd1);
        verifica("fora_pc4_pronto", {31'd0, busca_pronto}, 32'd1);
        pc = 26'h3FF_FFFF;
        tick();
        verifica("fora_max_instr", instrucao, HALT);
        verifica("fora_max_erro", {31'd0, erro_pc}, 32'd1);
        pc = 26'd2;
        tick();
        verifica("apos_erro_instr", instrucao, 32'h33);
        verifica("erro_pegajoso", {31'd0, erro_pc}, 32'd1);

        // Pre-emption: load start and fetch request together.
        carga_inicio = 1'b1; busca_req = 1'b1; pc = 26'd0;
        tick();
        carga_inicio = 1'b0; busca_req = 1'b0;
        verifica("preempt_pronto", {31'd0, busca_pronto}, 32'd0);
        verifica("preempt_cpu", {31'd0, cpu_liberado}, 32'd0);
        verifica("preempt_palavras", {24'd0, palavras}, 32'd0);
        verifica("preempt_carga_pronto", {31'd0, carga_pronto}, 32'd1);
        verifica("preempt_erro_limpo", {31'd0, erro_pc}, 32'd0);
        verifica("preempt_instr_mantida", instrucao, 32'h33);

        // Reload two words; the second arrives together with carga_fim.
        carga_valido = 1'b1; carga_dado = 32'hA0;
        tick();
        carga_dado = 32'hA1; carga_fim = 1'b1;
        tick();
        carga_valido = 1'b0; carga_fim = 1'b0;
        verifica("fim_junto_palavras", {24'd0, palavras}, 32'd2);
        verifica("fim_junto_cpu", {31'd0, cpu_liberado}, 32'd1);
        busca_req = 1'b1; pc = 26'd1;
        tick();
        verifica("recarga_pc1", instrucao, 32'hA1);
        pc = 26'd2;   // store still holds 0x33 here, must not leak
        tick();
        busca_req = 1'b0;
        verifica("recarga_pc2_halt", instrucao, HALT);
        verifica("recarga_pc2_erro", {31'd0, erro_pc}, 32'd1);

        // Overflow: 153 words with valid held high.
        carga_inicio = 1'b1;
        tick();
        carga_inicio = 1'b0;
        for (int i = 0; i < 153; i++) begin
            carga_valido = 1'b1; carga_dado = 32'h1000 + i;
            tick();
            if (i == 148) begin
                verifica("estouro_pronto_149", {31'd0, carga_pronto}, 32'd1);
            end
        end
        carga_valido = 1'b0;
        verifica("estouro_carga_pronto", {31'd0, carga_pronto}, 32'd0);
        verifica("estouro_palavras", {24'd0, palavras}, 32'd150);
        carga_fim = 1'b1;
        tick();
        carga_fim = 1'b0;
        busca_req = 1'b1; pc = 26'd149;
        tick();
        verifica("estouro_pc149", instrucao, 32'h1000 + 32'd149);
        verifica("estouro_pc149_erro", {31'd0, erro_pc}, 32'd0);
        pc = 26'd0;
        tick();
        verifica("estouro_pc0", instrucao, 32'h1000);
        pc = 26'd150;
        tick();
        busca_req = 1'b0;
        verifica("estouro_pc150", instrucao, HALT);
        verifica("estouro_pc150_erro", {31'd0, erro_pc}, 32'd1);

        // Reset in the middle of a load overrides the coincident word.
        carga_inicio = 1'b1;
        tick();
        carga_inicio = 1'b0;
        carga_valido = 1'b1; carga_dado = 32'hBEEF;
        tick();
        verifica("meio_carga_palavras", {24'd0, palavras}, 32'd1);
        reset = 1'b1;
        tick();
        verifica_reset("rst_meio");
        reset = 1'b0; carga_valido = 1'b0;
        tick();
        verifica("pos_rst_cpu", {31'd0, cpu_liberado}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
